// File: rtl/n64_poll_tx_if.sv
// Handshake bundle between the N64 poll transmitter and its host/receiver side.
// The master drives scheduling and receiver inputs; the slave (transmitter) drives line and status.
interface n64_poll_tx_if;
  logic enable;
  logic poll_req;
  logic rx_valid;
  logic line_oe;
  logic busy;
  logic resp_window;
  logic done;
  logic timeout;

  modport master (
    output enable, poll_req, rx_valid,
    input  line_oe, busy, resp_window, done, timeout
  );

  modport slave (
    input  enable, poll_req, rx_valid,
    output line_oe, busy, resp_window, done, timeout
  );
endinterface

// File: rtl/n64_poll_tx.sv
// Host-side N64 command transmitter: sends CMD plus a stop bit on the open-drain line,
// then opens a response window until the receiver reports a word or the wait times out.
module n64_poll_tx #(
  parameter int         CLK_PER_US     = 4,
  parameter logic [7:0] CMD            = 8'h01,
  parameter int         POLL_PERIOD_US = 16667,
  parameter int         TIMEOUT_US     = 200
) (
  input  logic         clk,
  input  logic         reset,
  n64_poll_tx_if.slave bus
);

  localparam int US      = CLK_PER_US;
  localparam int PER_CYC = POLL_PERIOD_US * US;
  localparam int TMO_CYC = TIMEOUT_US * US;
  localparam int PH_CYC  = 3 * US;

  localparam int PER_W = (PER_CYC > 1) ? $clog2(PER_CYC) : 1;
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam int PH_W  = (PH_CYC  > 1) ? $clog2(PH_CYC)  : 1;

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PER_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [PH_W-1:0]  ONE_US   = PH_W'(US - 1);
  localparam logic [PH_W-1:0]  THREE_US = PH_W'(3 * US - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_STOP,
    S_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [7:0]       sh_q, sh_d;
  logic [2:0]       bit_q, bit_d;
  logic             line_oe_q, line_oe_d;
  logic             busy_q, busy_d;
  logic             resp_window_q, resp_window_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  logic             tick;
  logic             cur_bit;
  logic [PH_W-1:0]  low_last;
  logic [PH_W-1:0]  high_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pending_q     <= 1'b0;
      per_q         <= '0;
      tmo_q         <= '0;
      ph_q          <= '0;
      sh_q          <= '0;
      bit_q         <= '0;
      line_oe_q     <= 1'b0;
      busy_q        <= 1'b0;
      resp_window_q <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      per_q         <= per_d;
      tmo_q         <= tmo_d;
      ph_q          <= ph_d;
      sh_q          <= sh_d;
      bit_q         <= bit_d;
      line_oe_q     <= line_oe_d;
      busy_q        <= busy_d;
      resp_window_q <= resp_window_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
    end
  end

  // Bit cell: a '1' is short-low/long-high, a '0' is long-low/short-high; both 4 us.
  always_comb begin
    cur_bit   = sh_q[7];
    low_last  = cur_bit ? ONE_US   : THREE_US;
    high_last = cur_bit ? THREE_US : ONE_US;
  end

  always_comb begin
    tick = bus.enable && (per_q == PER_LAST);
    if (!bus.enable || tick) per_d = '0;
    else                     per_d = per_q + PER_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | tick | bus.poll_req;
    tmo_d     = tmo_q;
    ph_d      = ph_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          // A request landing on the dispatch cycle is served by the frame now starting.
          pending_d = 1'b0;
          sh_d      = CMD;
          bit_d     = 3'd7;
          ph_d      = '0;
          state_d   = S_LOW;
        end
      end

      S_LOW: begin
        if (ph_q == low_last) begin
          ph_d    = '0;
          state_d = S_HIGH;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      S_HIGH: begin
        if (ph_q == high_last) begin
          ph_d = '0;
          if (bit_q == 3'd0) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q - 3'd1;
            sh_d    = {sh_q[6:0], 1'b0};
            state_d = S_LOW;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      S_STOP: begin
        if (ph_q == ONE_US) begin
          ph_d    = '0;
          tmo_d   = '0;
          state_d = S_WAIT;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      S_WAIT: begin
        // A reply on the expiry cycle still counts as a reply.
        if (bus.rx_valid) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    line_oe_d     = (state_d == S_LOW) || (state_d == S_STOP);
    busy_d        = (state_d != S_IDLE);
    resp_window_d = (state_d == S_WAIT);
  end

  assign bus.line_oe     = line_oe_q;
  assign bus.busy        = busy_q;
  assign bus.resp_window = resp_window_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_n64_poll_tx.sv
// Scoreboard bench for n64_poll_tx: stimulus queues expected frames/pulses with hand-derived
// cycle numbers; a negedge monitor captures frames and pulses and pops/compares them.
module tb_n64_poll_tx;
  localparam int US     = 4;
  localparam int PER_US = 100;
  localparam int TMO_US = 200;
  localparam int FLEN   = 133;

  typedef enum int {EV_FRAME = 0, EV_DONE = 1, EV_TMO = 2} ev_kind_e;
  typedef struct {
    ev_kind_e        kind;
    int              cyc;
    logic [FLEN-1:0] oe;
    logic [FLEN-1:0] rw;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  n64_poll_tx_if bus();

  n64_poll_tx #(
    .CLK_PER_US(US), .CMD(8'h01), .POLL_PERIOD_US(PER_US), .TIMEOUT_US(TMO_US)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  function automatic void chk(string nm, int act, int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0d)", nm, act, exp_v, cyc);
  endfunction

  function automatic void chk_vec(string nm, logic [FLEN-1:0] act, logic [FLEN-1:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp_v);
  endfunction

  // 0x01 MSB first: seven '0' cells (12 low / 4 high), one '1' cell (4 low / 12 high), stop 4 low.
  function automatic logic [FLEN-1:0] nominal_oe();
    logic [FLEN-1:0] v = '0;
    int i = 0;
    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < 12; j++) begin v[i] = 1'b1; i++; end
      i += 4;
    end
    for (int j = 0; j < 4; j++) begin v[i] = 1'b1; i++; end
    i += 12;
    for (int j = 0; j < 4; j++) begin v[i] = 1'b1; i++; end
    return v;
  endfunction

  function automatic void exp_frame(int s);
    ev_t e;
    e.kind = EV_FRAME; e.cyc = s; e.oe = nominal_oe();
    e.rw = '0; e.rw[FLEN-1] = 1'b1;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_pulse(ev_kind_e k, int c);
    ev_t e;
    e.kind = k; e.cyc = c; e.oe = '0; e.rw = '0;
    exp_q.push_back(e);
  endfunction

  function automatic void got(ev_kind_e k, int c, logic [FLEN-1:0] oe, logic [FLEN-1:0] rw);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_event: got kind %0d at t=%0d expected none", int'(k), c);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", int'(k), int'(e.kind));
    chk("event_cycle", c, e.cyc);
    if (k == EV_FRAME && e.kind == EV_FRAME) begin
      chk_vec("frame_line_oe", oe, e.oe);
      chk_vec("frame_resp_window", rw, e.rw);
    end
  endfunction

  // Monitor
  logic            cap = 1'b0;
  int              cap_n, cap_s;
  logic [FLEN-1:0] cap_oe, cap_rw;
  logic            prev_busy = 1'b0;

  initial forever begin
    @(negedge clk);
    if (cap) begin
      cap_oe[cap_n] = bus.line_oe;
      cap_rw[cap_n] = bus.resp_window;
      cap_n++;
      if (cap_n == FLEN) begin
        cap = 1'b0;
        got(EV_FRAME, cap_s, cap_oe, cap_rw);
      end
    end else if (bus.busy && !prev_busy) begin
      cap = 1'b1; cap_s = cyc; cap_oe = '0; cap_rw = '0;
      cap_oe[0] = bus.line_oe; cap_rw[0] = bus.resp_window; cap_n = 1;
    end
    if (bus.done) begin
      got(EV_DONE, cyc, '0, '0);
      chk("busy_at_done", int'(bus.busy), 0);
    end
    if (bus.timeout) got(EV_TMO, cyc, '0, '0);
    prev_busy = bus.busy;
  end

  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pulse_poll();
    bus.poll_req = 1'b1; @(negedge clk); bus.poll_req = 1'b0;
  endtask

  task automatic pulse_rx();
    bus.rx_valid = 1'b1; @(negedge clk); bus.rx_valid = 1'b0;
  endtask

  // Stimulus: a poll issued in cycle p drives the line from p+2; window opens 132 cycles later.
  initial begin
    int p, s, w, w2, e, t;
    ev_t ab;
    bus.enable = 1'b0; bus.poll_req = 1'b0; bus.rx_valid = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_line_oe", int'(bus.line_oe), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_resp_window", int'(bus.resp_window), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_timeout", int'(bus.timeout), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reply 300 cycles after release; a stray rx_valid mid-frame is ignored.
    p = cyc; s = p + 2; w = s + 132;
    exp_frame(s); exp_pulse(EV_DONE, w + 301);
    pulse_poll();
    wait_cyc(s + 10); pulse_rx();
    wait_cyc(w + 300); pulse_rx();
    wait_cyc(w + 320);

    // No reply: timeout 800 cycles after the window opens.
    p = cyc; s = p + 2; w = s + 132;
    exp_frame(s); exp_pulse(EV_TMO, w + 800);
    pulse_poll();
    wait_cyc(w + 810);

    // Reply on the expiry cycle: done wins.
    p = cyc; s = p + 2; w = s + 132;
    exp_frame(s); exp_pulse(EV_DONE, w + 800);
    pulse_poll();
    wait_cyc(w + 799); pulse_rx();
    wait_cyc(w + 810);

    // Requests while busy collapse into one extra frame right after return to idle.
    p = cyc; s = p + 2; w = s + 132; w2 = w + 7 + 132;
    exp_frame(s); exp_pulse(EV_DONE, w + 6);
    exp_frame(w + 7); exp_pulse(EV_DONE, w2 + 6);
    pulse_poll();
    wait_cyc(s + 20); pulse_poll();
    wait_cyc(s + 60); pulse_poll();
    wait_cyc(w + 5); pulse_rx();
    wait_cyc(w2 + 5); pulse_rx();
    wait_cyc(w2 + 20);

    // Reset mid-S_LOW: line drops on that edge, pending is discarded, no pulses.
    p = cyc; s = p + 2;
    ab.kind = EV_FRAME; ab.cyc = s; ab.oe = '0; ab.rw = '0;
    for (int i = 0; i < 6; i++) ab.oe[i] = 1'b1;
    exp_q.push_back(ab);
    pulse_poll();
    wait_cyc(s + 2); pulse_poll();
    wait_cyc(s + 5); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("reset_mid_line_oe", int'(bus.line_oe), 0);
    chk("reset_mid_busy", int'(bus.busy), 0);
    wait_cyc(s + 1000);

    // Auto-poll every 400 cycles; poll_req coincident with the second tick adds nothing.
    e = cyc; bus.enable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      exp_frame(e + 1 + 400 * k);
      exp_pulse(EV_DONE, e + 1 + 400 * k + 143);
    end
    for (int k = 1; k <= 3; k++) begin
      if (k == 2) begin wait_cyc(e + 799); pulse_poll(); end
      wait_cyc(e + 1 + 400 * k + 142); pulse_rx();
    end
    wait_cyc(e + 1350); bus.enable = 1'b0;
    wait_cyc(e + 1900);

    t = 0;
    while ((exp_q.size() != 0 || cap) && t < 2000) begin @(negedge clk); t++; end
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
